alu_md: RTL and testbench

- Parametrised successor to the single-cycle RV32I ALU.
- Full RV32I integer op set is combinational: add, sub, and, or, xor, slt, sltu, sll, srl, sra, with {N,Z,C,V} flags.
- Adds an iterative RV32M multiply/divide engine with a start/busy/done handshake.
- Sits in the execute stage; the controller stalls on Busy.

---
 rtl/alu_md.sv | 215 +++++++++++++++++++++
 tb/tb_alu_md.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_md.sv
`default_nettype none
// ============================================================================
//  Module      : alu_md
//  Description : RV32I combinational ALU with {N,Z,C,V} flags plus an
//                iterative RV32M multiply/divide engine (start/busy/done).
//  Revision    : 1.0 - initial release
// ============================================================================
module alu_md #(
    parameter int Width = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [Width-1:0] A,
    input  logic [Width-1:0] B,
    input  logic [4:0]       ALUCtrl,
    input  logic             Start,
    output logic [Width-1:0] Result,
    output logic [3:0]       Flags,
    output logic             Busy,
    output logic             Done,
    output logic [Width-1:0] MDResult
);

    localparam int ShW  = $clog2(Width);
    localparam int CntW = $clog2(Width) + 1;

    typedef enum logic [1:0] {S_IDLE = 2'd0, S_RUN = 2'd1, S_DONE = 2'd2} state_t;

    // ------------------------------------------------------------------
    // Combinational ALU
    // ------------------------------------------------------------------
    logic [3:0]       w_code;
    logic             w_sub;
    logic [Width-1:0] w_bop;
    logic [Width-1:0] w_sum;
    logic             w_cout;
    logic             w_ovf;
    logic [ShW-1:0]   w_shamt;
    logic             w_arith;

    // Shared adder: sub, slt and sltu all compute A + ~B + 1
    always_comb begin
        w_code  = ALUCtrl[3:0];
        w_sub   = (w_code == 4'd1) || (w_code == 4'd5) || (w_code == 4'd6);
        w_bop   = w_sub ? ~B : B;
        {w_cout, w_sum} = {1'b0, A} + {1'b0, w_bop} + {{Width{1'b0}}, w_sub};
        w_ovf   = (A[Width-1] == w_bop[Width-1]) && (w_sum[Width-1] != A[Width-1]);
        w_shamt = B[ShW-1:0];
        w_arith = ~ALUCtrl[4] && ((w_code == 4'd0) || (w_code == 4'd1));
    end

    // Result mux; M-extension codes drive zero on the combinational path
    always_comb begin
        Result = '0;
        if (!ALUCtrl[4]) begin
            case (w_code)
                4'd0, 4'd1: Result = w_sum;
                4'd2:       Result = A & B;
                4'd3:       Result = A | B;
                4'd4:       Result = A ^ B;
                4'd5:       Result = {{(Width-1){1'b0}}, w_sum[Width-1] ^ w_ovf};
                4'd6:       Result = {{(Width-1){1'b0}}, ~w_cout};
                4'd7:       Result = A << w_shamt;
                4'd8:       Result = A >> w_shamt;
                4'd9:       Result = $unsigned($signed(A) >>> w_shamt);
                default:    Result = '0;
            endcase
        end
    end

    // Flags {N,Z,C,V}; carry/overflow only meaningful for add/sub
    always_comb begin
        Flags = {Result[Width-1], (Result == '0), w_arith & w_cout, w_arith & w_ovf};
    end

    // ------------------------------------------------------------------
    // Iterative multiply/divide engine
    // ------------------------------------------------------------------
    state_t           state_q, state_d;
    logic [CntW-1:0]  cnt_q, cnt_d;
    logic [2:0]       op_q, op_d;
    logic             sa_q, sa_d, sb_q, sb_d;
    logic [Width-1:0] hi_q, hi_d, lo_q, lo_d, opb_q, opb_d, md_q, md_d;

    logic             w_accept, w_sa, w_sb, w_fast, w_dz, w_ovfd;
    logic [Width-1:0] w_aabs, w_babs, w_fastres;
    logic [Width:0]   w_mulsum, w_shift;
    logic [Width+1:0] w_diff;
    logic [Width-1:0] w_hi_n, w_lo_n, w_final;
    logic [2*Width-1:0] w_prod;
    logic             w_negp;

    // Launch decode: operand signs, magnitudes and division fast path
    always_comb begin
        w_accept = Start && ALUCtrl[4] && (state_q != S_RUN);
        w_sa     = A[Width-1] && ((ALUCtrl[2:0] == 3'b001) || (ALUCtrl[2:0] == 3'b010) ||
                                  (ALUCtrl[2:0] == 3'b100) || (ALUCtrl[2:0] == 3'b110));
        w_sb     = B[Width-1] && ((ALUCtrl[2:0] == 3'b001) || (ALUCtrl[2:0] == 3'b100) ||
                                  (ALUCtrl[2:0] == 3'b110));
        w_aabs   = w_sa ? -A : A;
        w_babs   = w_sb ? -B : B;
        w_dz     = (B == '0);
        w_ovfd   = ~ALUCtrl[0] && (A == {1'b1, {(Width-1){1'b0}}}) && (B == '1);
        w_fast   = ALUCtrl[2] && (w_dz || w_ovfd);
        if (w_dz)
            w_fastres = ALUCtrl[1] ? A : '1;
        else
            w_fastres = ALUCtrl[1] ? '0 : A;
    end

    // One shift-add or restoring shift-subtract step over {hi,lo}
    always_comb begin
        w_mulsum = {1'b0, hi_q} + (lo_q[0] ? {1'b0, opb_q} : {(Width+1){1'b0}});
        w_shift  = {hi_q, lo_q[Width-1]};
        w_diff   = {1'b0, w_shift} - {2'b00, opb_q};
        if (!op_q[2]) begin
            w_hi_n = w_mulsum[Width:1];
            w_lo_n = {w_mulsum[0], lo_q[Width-1:1]};
        end else if (!w_diff[Width+1]) begin
            w_hi_n = w_diff[Width-1:0];
            w_lo_n = {lo_q[Width-2:0], 1'b1};
        end else begin
            w_hi_n = w_shift[Width-1:0];
            w_lo_n = {lo_q[Width-2:0], 1'b0};
        end
    end

    // Sign correction of the final step's product / quotient / remainder
    always_comb begin
        w_negp = (op_q == 3'b001) ? (sa_q ^ sb_q) : ((op_q == 3'b010) ? sa_q : 1'b0);
        w_prod = {w_hi_n, w_lo_n};
        if (w_negp)
            w_prod = -w_prod;
        case (op_q)
            3'b000:                 w_final = w_prod[Width-1:0];
            3'b001, 3'b010, 3'b011: w_final = w_prod[2*Width-1:Width];
            3'b100:                 w_final = (sa_q ^ sb_q) ? -w_lo_n : w_lo_n;
            3'b101:                 w_final = w_lo_n;
            3'b110:                 w_final = sa_q ? -w_hi_n : w_hi_n;
            default:                w_final = w_hi_n;
        endcase
    end

    // Next-state logic; a launch may overlap the DONE cycle
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        op_d    = op_q;
        sa_d    = sa_q;
        sb_d    = sb_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        opb_d   = opb_q;
        md_d    = md_q;
        case (state_q)
            S_RUN: begin
                hi_d  = w_hi_n;
                lo_d  = w_lo_n;
                cnt_d = cnt_q + CntW'(1);
                if (cnt_q == CntW'(Width-1)) begin
                    state_d = S_DONE;
                    md_d    = w_final;
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: ;
        endcase
        if (w_accept) begin
            op_d  = ALUCtrl[2:0];
            sa_d  = w_sa;
            sb_d  = w_sb;
            hi_d  = '0;
            lo_d  = w_aabs;
            opb_d = w_babs;
            cnt_d = '0;
            if (w_fast) begin
                state_d = S_DONE;
                md_d    = w_fastres;
            end else begin
                state_d = S_RUN;
            end
        end
    end

    // Engine state register with asynchronous abort
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            op_q    <= '0;
            sa_q    <= 1'b0;
            sb_q    <= 1'b0;
            hi_q    <= '0;
            lo_q    <= '0;
            opb_q   <= '0;
            md_q    <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            op_q    <= op_d;
            sa_q    <= sa_d;
            sb_q    <= sb_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            opb_q   <= opb_d;
            md_q    <= md_d;
        end
    end

    assign Busy     = (state_q == S_RUN);
    assign Done     = (state_q == S_DONE);
    assign MDResult = md_q;

endmodule
`default_nettype wire

// File: tb/tb_alu_md.sv
`default_nettype none
// ============================================================================
//  Module      : tb_alu_md
//  Description : Directed self-checking bench for alu_md.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_alu_md;

    logic        clk;
    logic        reset;
    logic [31:0] A, B;
    logic [4:0]  ALUCtrl;
    logic        Start;
    logic [31:0] Result;
    logic [3:0]  Flags;
    logic        Busy, Done;
    logic [31:0] MDResult;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [4:0]  c;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] r;
        logic [3:0]  f;
    } cvec_t;

    alu_md #(.Width(32)) dut (
        .clk(clk), .reset(reset), .A(A), .B(B), .ALUCtrl(ALUCtrl), .Start(Start),
        .Result(Result), .Flags(Flags), .Busy(Busy), .Done(Done), .MDResult(MDResult)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic test_reset;
        reset = 1'b1; A = '0; B = '0; ALUCtrl = '0; Start = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if (Busy !== 1'b0 || Done !== 1'b0 || MDResult !== 32'h0) begin
            errors++;
            $display("FAIL reset_state busy=%b done=%b md=%h expected 0 0 00000000", Busy, Done, MDResult);
        end
        reset = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_comb;
        cvec_t v [14];
        v[0]  = '{5'h00, 32'h7FFFFFFF, 32'h00000001, 32'h80000000, 4'b1001};
        v[1]  = '{5'h01, 32'h00000005, 32'h00000005, 32'h00000000, 4'b0110};
        v[2]  = '{5'h09, 32'h80000000, 32'h00000004, 32'hF8000000, 4'b1000};
        v[3]  = '{5'h06, 32'h00000001, 32'hFFFFFFFF, 32'h00000001, 4'b0000};
        v[4]  = '{5'h05, 32'h00000001, 32'hFFFFFFFF, 32'h00000000, 4'b0100};
        v[5]  = '{5'h02, 32'hF0F0F0F0, 32'hFF00FF00, 32'hF000F000, 4'b1000};
        v[6]  = '{5'h03, 32'h0F0F0000, 32'h000000F0, 32'h0F0F00F0, 4'b0000};
        v[7]  = '{5'h04, 32'hFFFF0000, 32'hFFFFFFFF, 32'h0000FFFF, 4'b0000};
        v[8]  = '{5'h07, 32'h00000001, 32'h00000023, 32'h00000008, 4'b0000};
        v[9]  = '{5'h08, 32'h80000000, 32'h0000001F, 32'h00000001, 4'b0000};
        v[10] = '{5'h00, 32'hFFFFFFFF, 32'h00000001, 32'h00000000, 4'b0110};
        v[11] = '{5'h0A, 32'h12345678, 32'h9ABCDEF0, 32'h00000000, 4'b0100};
        v[12] = '{5'h10, 32'h12345678, 32'h9ABCDEF0, 32'h00000000, 4'b0100};
        v[13] = '{5'h01, 32'h80000000, 32'h00000001, 32'h7FFFFFFF, 4'b0011};
        Start = 1'b0;
        for (int i = 0; i < 14; i++) begin
            @(negedge clk);
            ALUCtrl = v[i].c; A = v[i].a; B = v[i].b;
            #1;
            checks++;
            if (Result !== v[i].r || Flags !== v[i].f) begin
                errors++;
                $display("FAIL comb_%0d ctrl=%h result=%h flags=%b expected %h %b",
                         i, v[i].c, Result, Flags, v[i].r, v[i].f);
            end
        end
    endtask

    // Launch one M op and watch Busy/Done/MDResult for 40 cycles
    task automatic md_op(input string name, input logic [2:0] op, input logic [31:0] a,
                         input logic [31:0] b, input logic [31:0] exp, input bit fast,
                         input bit perturb);
        int busy_n = 0;
        int done_n = 0;
        int done_at = 0;
        logic [31:0] got = '0;
        @(negedge clk);
        A = a; B = b; ALUCtrl = {2'b10, op}; Start = 1'b1;
        for (int i = 1; i <= 40; i++) begin
            @(negedge clk);
            if (i == 1) Start = 1'b0;
            if (perturb && i == 5) begin A = ~a; B = 32'h3; Start = 1'b1; end
            if (perturb && i == 6) Start = 1'b0;
            if (Busy) busy_n++;
            if (Done) begin
                done_n++;
                if (done_at == 0) begin done_at = i; got = MDResult; end
            end
        end
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s result got=%h expected=%h", name, got, exp);
        end
        checks++;
        if (done_at != (fast ? 1 : 33)) begin
            errors++;
            $display("FAIL %s done_cycle got=%0d expected=%0d", name, done_at, fast ? 1 : 33);
        end
        checks++;
        if (busy_n != (fast ? 0 : 32)) begin
            errors++;
            $display("FAIL %s busy_cycles got=%0d expected=%0d", name, busy_n, fast ? 0 : 32);
        end
        checks++;
        if (done_n != 1) begin
            errors++;
            $display("FAIL %s done_pulses got=%0d expected=1", name, done_n);
        end
    endtask

    task automatic test_mul;
        md_op("mulh_m2x3",    3'b001, 32'hFFFFFFFE, 32'h00000003, 32'hFFFFFFFF, 1'b0, 1'b0);
        md_op("mulhu_max",    3'b011, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 1'b0, 1'b0);
        md_op("mul_max",      3'b000, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000001, 1'b0, 1'b0);
        md_op("mulhsu_m1x2",  3'b010, 32'hFFFFFFFF, 32'h00000002, 32'hFFFFFFFF, 1'b0, 1'b0);
    endtask

    task automatic test_div;
        md_op("div_m7_2",     3'b100, 32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFD, 1'b0, 1'b0);
        md_op("rem_m7_2",     3'b110, 32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFF, 1'b0, 1'b0);
        md_op("divu_100_7",   3'b101, 32'd100,      32'd7,        32'd14,       1'b0, 1'b0);
        md_op("remu_100_7",   3'b111, 32'd100,      32'd7,        32'd2,        1'b0, 1'b0);
        md_op("div_7_m2",     3'b100, 32'd7,        32'hFFFFFFFE, 32'hFFFFFFFD, 1'b0, 1'b0);
        md_op("rem_7_m2",     3'b110, 32'd7,        32'hFFFFFFFE, 32'h00000001, 1'b0, 1'b0);
        md_op("divu_min_m1",  3'b101, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 1'b0, 1'b0);
        md_op("remu_min_m1",  3'b111, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 1'b0, 1'b0);
    endtask

    task automatic test_special;
        md_op("div_9_0",      3'b100, 32'd9,        32'd0,        32'hFFFFFFFF, 1'b1, 1'b0);
        md_op("rem_9_0",      3'b110, 32'd9,        32'd0,        32'd9,        1'b1, 1'b0);
        md_op("divu_9_0",     3'b101, 32'd9,        32'd0,        32'hFFFFFFFF, 1'b1, 1'b0);
        md_op("remu_9_0",     3'b111, 32'd9,        32'd0,        32'd9,        1'b1, 1'b0);
        md_op("div_ovf",      3'b100, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 1'b1, 1'b0);
        md_op("rem_ovf",      3'b110, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 1'b1, 1'b0);
    endtask

    task automatic test_midrun_changes;
        md_op("divu_perturb", 3'b101, 32'd100,      32'd7,        32'd14,       1'b0, 1'b1);
        md_op("mulh_perturb", 3'b001, 32'hFFFFFFFE, 32'h00000003, 32'hFFFFFFFF, 1'b0, 1'b1);
    endtask

    task automatic test_back_to_back;
        int first = 0;
        int second = 0;
        @(negedge clk);
        A = 32'hFFFFFFFF; B = 32'hFFFFFFFF; ALUCtrl = 5'b10011; Start = 1'b1;
        for (int i = 1; i <= 80; i++) begin
            @(negedge clk);
            if (i == 1) Start = 1'b0;
            if (first == 0) begin
                if (Done) begin
                    first = i;
                    checks++;
                    if (MDResult !== 32'hFFFFFFFE) begin
                        errors++;
                        $display("FAIL b2b_first got=%h expected=fffffffe", MDResult);
                    end
                    A = 32'd100; B = 32'd7; ALUCtrl = 5'b10101; Start = 1'b1;
                end
            end else begin
                if (i == first + 1) Start = 1'b0;
                if (Done && second == 0) begin
                    second = i;
                    checks++;
                    if (MDResult !== 32'd14) begin
                        errors++;
                        $display("FAIL b2b_second got=%h expected=0000000e", MDResult);
                    end
                end
            end
        end
        checks++;
        if (first == 0 || second == 0 || (second - first) != 33) begin
            errors++;
            $display("FAIL b2b_spacing first=%0d second=%0d expected spacing 33", first, second);
        end
    endtask

    task automatic test_reset_midrun;
        int done_n = 0;
        @(negedge clk);
        A = 32'hFFFFFFF9; B = 32'd2; ALUCtrl = 5'b10100; Start = 1'b1;
        for (int i = 1; i <= 10; i++) begin
            @(negedge clk);
            if (i == 1) Start = 1'b0;
        end
        checks++;
        if (Busy !== 1'b1) begin
            errors++;
            $display("FAIL midrun_busy got=%b expected=1", Busy);
        end
        reset = 1'b1;
        #1;
        checks++;
        if (Busy !== 1'b0 || Done !== 1'b0 || MDResult !== 32'h0) begin
            errors++;
            $display("FAIL midrun_reset busy=%b done=%b md=%h expected 0 0 00000000", Busy, Done, MDResult);
        end
        @(negedge clk);
        reset = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (Done) done_n++;
        end
        checks++;
        if (done_n != 0) begin
            errors++;
            $display("FAIL midrun_no_done got=%0d expected=0", done_n);
        end
        md_op("mul_3x4", 3'b000, 32'd3, 32'd4, 32'd12, 1'b0, 1'b0);
    endtask

    initial begin
        test_reset;
        test_comb;
        test_mul;
        test_div;
        test_special;
        test_midrun_changes;
        test_back_to_back;
        test_reset_midrun;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
